// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory dump arbiter.
// Holds the dump FSM state encoding and the word-to-byte-address mapping.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  localparam int unsigned WORD_BYTES_DEFAULT = 8;

  // Byte address of dumped word idx; callers resize the result to their bus width.
  function automatic logic [63:0] word_addr(input logic [31:0] idx,
                                            input logic [31:0] wordBytes);
    return 64'(idx) * 64'(wordBytes);
  endfunction

endpackage

// File: rtl/dump_sequencer.sv
// Edge-triggered dump sequencer: detects a rising dump request, walks DEPTH
// word indices, then issues a one-cycle done pulse before releasing the port.
module dump_sequencer
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dump,
  output logic             o_active,
  output logic             o_dumpValid,
  output logic             o_dumpDone,
  output logic [IDX_W-1:0] o_idx
);

  dump_state_t      r_state;
  dump_state_t      w_nextState;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_nextIdx;
  logic             r_dumpQ;
  logic             w_start;

  // The edge register clears on reset, so a request held high across reset starts a dump.
  assign w_start = i_dump & ~r_dumpQ;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_dumpQ <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_idx   <= w_nextIdx;
      r_dumpQ <= i_dump;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    o_active    = 1'b0;
    o_dumpValid = 1'b0;
    o_dumpDone  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_nextState = DUMP;
          w_nextIdx   = '0;
        end
      end
      DUMP: begin
        o_active    = 1'b1;
        o_dumpValid = 1'b1;
        if (r_idx == IDX_W'(DEPTH - 1)) begin
          w_nextState = DONE;
          w_nextIdx   = '0;
        end else begin
          w_nextIdx = r_idx + IDX_W'(1);
        end
      end
      DONE: begin
        o_active    = 1'b1;
        o_dumpDone  = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
        w_nextIdx   = '0;
      end
    endcase
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/dmem_dump_arbiter.sv
// Data-memory port arbiter: passes MEM-stage accesses through and, on a dump
// request, stalls the pipeline while the sequencer streams memory out.
module dmem_dump_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N          = 64,
  parameter int DEPTH      = 32,
  parameter int WORD_BYTES = WORD_BYTES_DEFAULT
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         dump,
  input  logic [N-1:0] cpu_addr,
  input  logic [N-1:0] cpu_wdata,
  input  logic         cpu_we,
  output logic [N-1:0] cpu_rdata,
  output logic         cpu_stall,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [N-1:0] mem_rdata,
  output logic         dump_valid,
  output logic [N-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_done
);

  localparam int IDX_W = $clog2(DEPTH);

  logic             w_active;
  logic             w_dumpValid;
  logic             w_dumpDone;
  logic [IDX_W-1:0] w_idx;
  logic [N-1:0]     w_dumpAddr;

  dump_sequencer #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_seq (
    .i_clk      (CLOCK_50),
    .i_rst      (reset),
    .i_dump     (dump),
    .o_active   (w_active),
    .o_dumpValid(w_dumpValid),
    .o_dumpDone (w_dumpDone),
    .o_idx      (w_idx)
  );

  assign w_dumpAddr = N'(word_addr(32'(w_idx), 32'(WORD_BYTES)));

  // The CPU owns the port by default; the dumper takes over the address and
  // blocks writes for the whole stalled window, including the done cycle.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_we;
    cpu_rdata = mem_rdata;
    dump_addr = '0;
    dump_data = '0;
    if (w_active) begin
      mem_we    = 1'b0;
      cpu_rdata = '0;
    end
    if (w_dumpValid) begin
      mem_addr  = w_dumpAddr;
      dump_addr = w_dumpAddr;
      dump_data = mem_rdata;
    end
  end

  assign cpu_stall  = w_active;
  assign dump_valid = w_dumpValid;
  assign dump_done  = w_dumpDone;

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Self-checking bench for dmem_dump_arbiter: vector table for reset/passthrough,
// scoreboard of expected dump words checked by a monitor during each dump.
module tb_dmem_dump_arbiter;

  logic        clk;
  logic        reset;
  logic        dump;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_we;
  logic [63:0] cpu_rdata;
  logic        cpu_stall;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic [63:0] mem_rdata;
  logic        dump_valid;
  logic [63:0] dump_addr;
  logic [63:0] dump_data;
  logic        dump_done;

  dmem_dump_arbiter #(
    .N(64),
    .DEPTH(32),
    .WORD_BYTES(8)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .dump      (dump),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_done (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  logic [63:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[8:3]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[8:3]] <= mem_wdata;
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        expMemWe;
    logic [63:0] expMemAddr;
    logic [63:0] expMemWdata;
    logic        chkRdata;
    logic [63:0] expRdata;
    logic        expStall;
  } vec_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;

  vec_t        vecs [5];
  exp_t        expQ [$];
  logic [63:0] shadow [0:31];

  int compareCount = 0;
  int failCount    = 0;
  int validCount   = 0;
  int doneCount    = 0;
  int stallCount   = 0;
  int weInStall    = 0;
  int runLen       = 0;
  int lastRun      = 0;
  logic prevValid  = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input vec_t v);
    @(negedge clk);
    reset     = v.rst;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    #2;
    checkOutput($sformatf("vec%0d.mem_we", i), 64'(mem_we), 64'(v.expMemWe));
    checkOutput($sformatf("vec%0d.mem_addr", i), mem_addr, v.expMemAddr);
    checkOutput($sformatf("vec%0d.mem_wdata", i), mem_wdata, v.expMemWdata);
    checkOutput($sformatf("vec%0d.cpu_stall", i), 64'(cpu_stall), 64'(v.expStall));
    checkOutput($sformatf("vec%0d.dump_valid", i), 64'(dump_valid), 64'd0);
    checkOutput($sformatf("vec%0d.dump_done", i), 64'(dump_done), 64'd0);
    checkOutput($sformatf("vec%0d.dump_addr", i), dump_addr, 64'd0);
    if (v.chkRdata) checkOutput($sformatf("vec%0d.cpu_rdata", i), cpu_rdata, v.expRdata);
  endtask

  task automatic cpuWrite(input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    shadow[addr[7:3]] = data;
  endtask

  task automatic pushAll();
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.addr = 64'(k * 8);
      e.data = shadow[k];
      expQ.push_back(e);
    end
  endtask

  task automatic pulseDump();
    @(negedge clk);
    dump   = 1'b1;
    cpu_we = 1'b0;
    pushAll();
    @(negedge clk);
    dump = 1'b0;
  endtask

  task automatic waitForDone(input string name, input int budget);
    int start;
    bit seen;
    start = doneCount;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #3;
      if (doneCount > start) seen = 1'b1;
    end
    compareCount++;
    if (!seen) begin
      failCount++;
      $display("[TB] FAIL %s: dump_done not seen within %0d cycles", name, budget);
    end
  endtask

  // Monitor: counts stall/valid/done cycles and pops the scoreboard on each valid word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (cpu_stall) begin
        stallCount++;
        if (mem_we) weInStall++;
      end
      if (dump_valid) begin
        validCount++;
        runLen++;
        if (expQ.size() == 0) begin
          compareCount++;
          failCount++;
          $display("[TB] FAIL unexpected_word: got addr 0x%0h, expected no word", dump_addr);
        end else begin
          e = expQ.pop_front();
          checkOutput("dump_addr", dump_addr, e.addr);
          checkOutput("dump_data", dump_data, e.data);
          checkOutput("mem_we_in_dump", 64'(mem_we), 64'd0);
          checkOutput("cpu_rdata_in_dump", cpu_rdata, 64'd0);
        end
      end else if (runLen != 0) begin
        lastRun = runLen;
        runLen  = 0;
      end
      if (dump_done) begin
        doneCount++;
        checkOutput("done_after_last_word", 64'(prevValid), 64'd1);
      end
      prevValid = dump_valid;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sValid, sDone, sStall, sWe;

    reset     = 1'b1;
    dump      = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;

    vecs[0] = '{1'b1, 1'b1, 64'h10, 64'hAA,   1'b1, 64'h10, 64'hAA,   1'b0, 64'h0,    1'b0};
    vecs[1] = '{1'b1, 1'b1, 64'h10, 64'hAA,   1'b1, 64'h10, 64'hAA,   1'b1, 64'hAA,   1'b0};
    vecs[2] = '{1'b0, 1'b1, 64'h18, 64'h1234, 1'b1, 64'h18, 64'h1234, 1'b0, 64'h0,    1'b0};
    vecs[3] = '{1'b0, 1'b0, 64'h18, 64'h0,    1'b0, 64'h18, 64'h0,    1'b1, 64'h1234, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 64'h10, 64'h5,    1'b0, 64'h10, 64'h5,    1'b1, 64'hAA,   1'b0};

    $display("[TB] reset and idle passthrough vectors");
    for (int i = 0; i < 5; i++) applyStimulus(i, vecs[i]);

    $display("[TB] preload and full dump");
    for (int k = 0; k < 32; k++) cpuWrite(64'(k * 8), 64'(k + 100));
    sValid = validCount; sDone = doneCount; sStall = stallCount; sWe = weInStall;
    pulseDump();
    waitForDone("s3_done", 60);
    repeat (2) @(negedge clk);
    #3;
    checkOutput("s3_valid_count", 64'(validCount - sValid), 64'd32);
    checkOutput("s3_valid_run", 64'(lastRun), 64'd32);
    checkOutput("s3_stall_cycles", 64'(stallCount - sStall), 64'd33);
    checkOutput("s3_done_count", 64'(doneCount - sDone), 64'd1);
    checkOutput("s3_we_in_stall", 64'(weInStall - sWe), 64'd0);
    checkOutput("s3_queue_left", 64'(expQ.size()), 64'd0);
    checkOutput("s3_stall_after", 64'(cpu_stall), 64'd0);

    $display("[TB] dump raised with a same-cycle write, held high");
    sValid = validCount; sDone = doneCount;
    @(negedge clk);
    dump      = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 64'h20;
    cpu_wdata = 64'hBEEF;
    shadow[4] = 64'hBEEF;
    pushAll();
    @(negedge clk);
    cpu_we = 1'b0;
    repeat (99) @(negedge clk);
    dump = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    checkOutput("s4_done_count", 64'(doneCount - sDone), 64'd1);
    checkOutput("s4_valid_count", 64'(validCount - sValid), 64'd32);
    checkOutput("s4_queue_left", 64'(expQ.size()), 64'd0);

    $display("[TB] reset in the middle of a dump");
    sValid = validCount; sDone = doneCount;
    pulseDump();
    begin
      bit reached;
      reached = 1'b0;
      for (int i = 0; i < 60 && !reached; i++) begin
        if (validCount - sValid >= 10) reached = 1'b1;
        else begin
          @(negedge clk);
          #3;
        end
      end
      compareCount++;
      if (!reached) begin
        failCount++;
        $display("[TB] FAIL s5_tenth_word: got %0d words, expected 10", validCount - sValid);
      end
    end
    reset = 1'b1;
    #1;
    checkOutput("s5_stall_in_reset", 64'(cpu_stall), 64'd0);
    checkOutput("s5_valid_in_reset", 64'(dump_valid), 64'd0);
    checkOutput("s5_done_in_reset", 64'(dump_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    expQ.delete();
    repeat (3) @(negedge clk);
    #3;
    checkOutput("s5_no_done", 64'(doneCount - sDone), 64'd0);
    checkOutput("s5_partial_words", 64'(validCount - sValid), 64'd10);
    checkOutput("s5_idle_stall", 64'(cpu_stall), 64'd0);
    sValid = validCount; sDone = doneCount;
    pulseDump();
    waitForDone("s5_restart_done", 60);
    repeat (2) @(negedge clk);
    #3;
    checkOutput("s5_restart_words", 64'(validCount - sValid), 64'd32);
    checkOutput("s5_restart_done_count", 64'(doneCount - sDone), 64'd1);
    checkOutput("s5_queue_left", 64'(expQ.size()), 64'd0);

    $display("[TB] CPU write held during a dump");
    sValid = validCount; sWe = weInStall;
    @(negedge clk);
    dump   = 1'b1;
    cpu_we = 1'b0;
    pushAll();
    @(negedge clk);
    dump      = 1'b0;
    cpu_we    = 1'b1;
    cpu_addr  = 64'h0;
    cpu_wdata = 64'hFFFF;
    waitForDone("s6_done", 60);
    @(negedge clk);
    #3;
    checkOutput("s6_stall_released", 64'(cpu_stall), 64'd0);
    checkOutput("s6_mem_we_released", 64'(mem_we), 64'd1);
    checkOutput("s6_mem_addr_released", mem_addr, 64'h0);
    shadow[0] = 64'hFFFF;
    @(negedge clk);
    cpu_we = 1'b0;
    #3;
    checkOutput("s6_write_landed", cpu_rdata, 64'hFFFF);
    checkOutput("s6_we_in_stall", 64'(weInStall - sWe), 64'd0);
    checkOutput("s6_valid_count", 64'(validCount - sValid), 64'd32);
    checkOutput("s6_queue_left", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
